palette_fade_lut: RTL and testbench
===================================

// Module: palette_fade_lut
// PURPOSE
//  Writable, parametrised colour palette with a built-in screen fade sequencer.
//  Maps a per-pixel palette index to scaled RGB through a 2-stage pipeline.
//  Sits between sprite/screen ROM index outputs and the VGA colour mux.
//  Replaces fixed per-screen palettes, and fades start/endgame screens in and out.
// PARAMETERS
//  IDX_W     4  palette index width; 2**IDX_W entries
//  COLOR_W   4  bits per colour channel
//  FADE_DIV  2  frame_tick pulses per fade step (>=1)
// PORTS
//  Clk           in   1            system clock; all logic on rising edge
//  Reset_n       in   1            asynchronous, active-low reset
//  frame_tick    in   1            1-cycle pulse once per frame (vsync edge)
//  idx_valid     in   1            index is valid this cycle
//  index         in   IDX_W        palette index to look up
//  pal_we        in   1            palette write strobe
//  pal_waddr     in   IDX_W        write address
//  pal_wdata     in   3*COLOR_W    {r,g,b} write data
//  fade_in_req   in   1            pulse: start fading toward full brightness
//  fade_out_req  in   1            pulse: start fading toward black
//  red/green/blue out COLOR_W      scaled colour (registered)
//  rgb_valid     out  1            red/green/blue valid; idx_valid delayed 2 cycles
//  fade_level    out  COLOR_W+1    current level, 0..2**COLOR_W
//  fade_busy     out  1            high in FADE_IN/FADE_OUT
//  fade_done     out  1            1-cycle pulse when a fade reaches its end level
// BEHAVIOUR
//  Reset: all palette entries=0; red/green/blue=0; rgb_valid=0; fade_done=0.
//   Reset: state=SHOWN; fade_level=2**COLOR_W (LMAX); step counter=0.
//   Reset_n low mid-fade aborts the fade immediately to these values.
//  Writes: on an edge with pal_we=1, entry[pal_waddr] <= pal_wdata.
//  Pipeline stage 1: on idx_valid, register entry[index].
//   Same-cycle write to the same address bypasses: stage 1 takes pal_wdata.
//  Pipeline stage 2: each channel out = (c * fade_level) >> COLOR_W, truncated.
//   fade_level=LMAX returns c exactly; fade_level=0 returns 0.
//  Latency is exactly 2 cycles, with one result per cycle (no stalls).
//  rgb_valid follows idx_valid. Outputs hold their last value while rgb_valid=0.
//  Stage 2 uses fade_level as registered at stage-2 time.
//  FSM states: SHOWN(level=LMAX), FADE_OUT, DARK(level=0), FADE_IN.
//   SHOWN --fade_out_req--> FADE_OUT;  DARK --fade_in_req--> FADE_IN.
//   FADE_OUT --fade_in_req--> FADE_IN, reversing from the current level; symmetric for FADE_IN.
//   fade_in_req and fade_out_req in the same cycle: fade_out_req wins.
//   A request toward the current resting state (e.g. fade_in_req in SHOWN) is ignored, with no fade_done.
//  Stepping: in FADE_*, each frame_tick increments the step counter.
//   On the FADE_DIV-th tick: counter<=0; level -/+1.
//   Level reaches 0 (FADE_OUT) -> DARK, fade_done=1 for one cycle.
//   Level reaches LMAX (FADE_IN) -> SHOWN, fade_done=1 for one cycle.
//   The step counter clears on every state entry. frame_tick is ignored in SHOWN/DARK.
//  Full fade = LMAX*FADE_DIV frames (default 32 frames).
// CONFIGURATION
//  PAL_TRANSPARENT_EN defined:
//   adds output transparent (1 bit), pipelined alongside rgb_valid.
//   transparent=1 when the looked-up index==0; the sprite mux then shows the background.
//   Index 0 still returns entry[0] scaled. Reset value of transparent is 0.
//  PAL_TRANSPARENT_EN undefined: the port does not exist; index 0 is an ordinary colour.
// TESTING
//  Write entry 3={F,C,0}; idx_valid=1, index=3 -> 2 cycles later rgb=F,C,0, rgb_valid=1.
//  Write entry 5 and look up index 5 in the same cycle, wdata={1,2,3} -> rgb=1,2,3 (bypass).
//  Entry 1={F,8,4}; fade_out_req; FADE_DIV=2; 4 ticks -> fade_level=14, rgb=D,7,3.
//   Continue the fade: after 32 ticks total -> DARK, rgb=0,0,0, single fade_done.
//  FADE_OUT at level 10; fade_in_req -> FADE_IN from 10; 12 more ticks -> SHOWN, fade_done.
//  Both requests in the same cycle in SHOWN -> FADE_OUT. Reset_n low mid-fade -> level=16, SHOWN, rgb=0.
//  PAL_TRANSPARENT_EN: index 0 -> transparent=1 at 2 cycles; index 7 -> transparent=0.
//   Back-to-back indices 0,7,0 -> transparent 1,0,1.

Source files
------------

// File: rtl/palette_fade_lut.sv
// palette_fade_lut: writable colour palette with a screen fade sequencer.
// Index -> {r,g,b} lookup (stage 1), then brightness scaling (stage 2).
// Optional feature macro: PAL_TRANSPARENT_EN adds a 'transparent' output
// flagging lookups of index 0.
module palette_fade_lut #(
    parameter int IDX_W    = 4,
    parameter int COLOR_W  = 4,
    parameter int FADE_DIV = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_tick,
    input  logic                   idx_valid,
    input  logic [IDX_W-1:0]       index,
    input  logic                   pal_we,
    input  logic [IDX_W-1:0]       pal_waddr,
    input  logic [3*COLOR_W-1:0]   pal_wdata,
    input  logic                   fade_in_req,
    input  logic                   fade_out_req,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   rgb_valid,
    output logic [COLOR_W:0]       fade_level,
`ifdef PAL_TRANSPARENT_EN
    output logic                   transparent,
`endif
    output logic                   fade_busy,
    output logic                   fade_done
);

    localparam int NENT  = 1 << IDX_W;
    localparam int CNT_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [COLOR_W:0]   LMAX     = (COLOR_W+1)'(1 << COLOR_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FADE_DIV - 1);

    typedef enum logic [1:0] {SHOWN, FADE_OUT, DARK, FADE_IN} fade_state_t;

    fade_state_t            state;
    logic [CNT_W-1:0]       step_cnt;
    logic [3*COLOR_W-1:0]   pal [NENT];
    logic [3*COLOR_W-1:0]   s1_rgb;
    logic [1:0]             vld_pipe;   // [0]=stage 1, [1]=stage 2 (rgb_valid)
`ifdef PAL_TRANSPARENT_EN
    logic                   s1_trans;
`endif

    // (c * level) >> COLOR_W; level==LMAX gives c back exactly
    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [COLOR_W:0]   l);
        return COLOR_W'(({{COLOR_W{1'b0}}, c} * {{(COLOR_W-1){1'b0}}, l}) >> COLOR_W);
    endfunction

    // Palette storage, cleared on reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NENT; i++) pal[i] <= '0;
        end else if (pal_we) begin
            pal[pal_waddr] <= pal_wdata;
        end
    end

    // Stage 1: lookup, with same-cycle write bypass so a write is visible at once
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_rgb      <= '0;
            vld_pipe[0] <= 1'b0;
`ifdef PAL_TRANSPARENT_EN
            s1_trans    <= 1'b0;
`endif
        end else begin
            vld_pipe[0] <= idx_valid;
            if (idx_valid) begin
                s1_rgb <= (pal_we && pal_waddr == index) ? pal_wdata : pal[index];
`ifdef PAL_TRANSPARENT_EN
                s1_trans <= (index == '0);
`endif
            end
        end
    end

    // Stage 2: scale by the current fade level; outputs hold while not valid
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            vld_pipe[1] <= 1'b0;
`ifdef PAL_TRANSPARENT_EN
            transparent <= 1'b0;
`endif
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                red   <= scale(s1_rgb[3*COLOR_W-1:2*COLOR_W], fade_level);
                green <= scale(s1_rgb[2*COLOR_W-1:COLOR_W],   fade_level);
                blue  <= scale(s1_rgb[COLOR_W-1:0],           fade_level);
`ifdef PAL_TRANSPARENT_EN
                transparent <= s1_trans;
`endif
            end
        end
    end

    assign rgb_valid = vld_pipe[1];

    // Fade sequencer: requests take priority over a frame tick in the same cycle,
    // and fade_out_req wins over fade_in_req.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= SHOWN;
            fade_level <= LMAX;
            step_cnt   <= '0;
            fade_done  <= 1'b0;
        end else begin
            fade_done <= 1'b0;
            if (fade_out_req) begin
                if (state == SHOWN || state == FADE_IN) begin
                    state    <= FADE_OUT;
                    step_cnt <= '0;
                end
            end else if (fade_in_req) begin
                if (state == DARK || state == FADE_OUT) begin
                    state    <= FADE_IN;
                    step_cnt <= '0;
                end
            end else if (frame_tick && (state == FADE_OUT || state == FADE_IN)) begin
                if (step_cnt == CNT_LAST) begin
                    step_cnt <= '0;
                    if (state == FADE_OUT) begin
                        fade_level <= fade_level - 1'b1;
                        if (fade_level == (COLOR_W+1)'(1)) begin
                            state     <= DARK;
                            fade_done <= 1'b1;
                        end
                    end else begin
                        fade_level <= fade_level + 1'b1;
                        if (fade_level == LMAX - 1'b1) begin
                            state     <= SHOWN;
                            fade_done <= 1'b1;
                        end
                    end
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

    assign fade_busy = (state == FADE_OUT) || (state == FADE_IN);

endmodule

// File: tb/tb_palette_fade_lut.sv
// Directed bench for palette_fade_lut (default parameters: 4/4/2).
module tb_palette_fade_lut;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_tick, idx_valid, pal_we, fade_in_req, fade_out_req;
    logic [3:0]  index, pal_waddr;
    logic [11:0] pal_wdata;
    logic [3:0]  red, green, blue;
    logic        rgb_valid, fade_busy, fade_done;
    logic [4:0]  fade_level;
`ifdef PAL_TRANSPARENT_EN
    logic        transparent;
`endif

    int n_chk = 0;
    int n_err = 0;

    palette_fade_lut #(.IDX_W(4), .COLOR_W(4), .FADE_DIV(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .idx_valid(idx_valid), .index(index), .pal_we(pal_we),
        .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .fade_in_req(fade_in_req), .fade_out_req(fade_out_req),
        .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
        .fade_level(fade_level),
`ifdef PAL_TRANSPARENT_EN
        .transparent(transparent),
`endif
        .fade_busy(fade_busy), .fade_done(fade_done)
    );

    always #5 Clk = ~Clk;

    task automatic cyc;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
        cyc;
        pal_we = 1'b0;
    endtask

    // single lookup: checks 2-cycle latency and the scaled colour
    task automatic look(input string tag, input logic [3:0] i, input logic [11:0] exp);
        idx_valid = 1'b1; index = i;
        cyc;
        idx_valid = 1'b0;
        chk({tag, "_vld1"}, rgb_valid, 0);
        cyc;
        chk({tag, "_vld2"}, rgb_valid, 1);
        chk({tag, "_rgb"}, {red, green, blue}, exp);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1; cyc;
            frame_tick = 1'b0; cyc;
        end
    endtask

    task automatic req(input logic fin, input logic fout);
        fade_in_req = fin; fade_out_req = fout;
        cyc;
        fade_in_req = 1'b0; fade_out_req = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; frame_tick = 0; idx_valid = 0; pal_we = 0;
        fade_in_req = 0; fade_out_req = 0; index = 0; pal_waddr = 0; pal_wdata = 0;
        repeat (2) cyc;
        chk("rst_rgb", {red, green, blue}, 12'h000);
        chk("rst_vld", rgb_valid, 0);
        chk("rst_level", fade_level, 16);
        chk("rst_busy", fade_busy, 0);
        chk("rst_done", fade_done, 0);
        @(negedge Clk); Reset_n = 1'b1;
        cyc;

        // basic write + lookup
        wr(4'd3, 12'hFC0);
        look("lut3", 4'd3, 12'hFC0);

        // same-cycle write/lookup bypass
        pal_we = 1; pal_waddr = 4'd5; pal_wdata = 12'h123; idx_valid = 1; index = 4'd5;
        cyc;
        pal_we = 0; idx_valid = 0;
        cyc;
        chk("byp_vld", rgb_valid, 1);
        chk("byp_rgb", {red, green, blue}, 12'h123);
        cyc;
        chk("hold_vld", rgb_valid, 0);
        chk("hold_rgb", {red, green, blue}, 12'h123);

        // back-to-back lookups, one result per cycle
        idx_valid = 1; index = 4'd3; cyc;
        index = 4'd5; cyc;
        chk("b2b_0", {rgb_valid, red, green, blue}, 13'h1FC0);
        index = 4'd3; cyc;
        chk("b2b_1", {rgb_valid, red, green, blue}, 13'h1123);
        idx_valid = 0; cyc;
        chk("b2b_2", {rgb_valid, red, green, blue}, 13'h1FC0);

        // fade_in_req while already shown is ignored
        wr(4'd1, 12'hF84);
        req(1, 0);
        chk("ign_busy", fade_busy, 0);
        chk("ign_done", fade_done, 0);
        chk("ign_level", fade_level, 16);

        // fade out: level drops one per FADE_DIV ticks
        req(0, 1);
        chk("fo_busy", fade_busy, 1);
        tick(1);
        chk("fo_t1", fade_level, 16);
        tick(1);
        chk("fo_t2", fade_level, 15);
        tick(2);
        chk("fo_t4", fade_level, 14);
        look("fo14", 4'd1, 12'hD73);
        tick(27);
        chk("fo_t31", fade_level, 1);
        chk("fo_t31_done", fade_done, 0);
        frame_tick = 1; cyc; frame_tick = 0;
        chk("fo_end_done", fade_done, 1);
        chk("fo_end_level", fade_level, 0);
        chk("fo_end_busy", fade_busy, 0);
        cyc;
        chk("fo_done_pulse", fade_done, 0);
        look("dark", 4'd1, 12'h000);
        tick(2);
        chk("dark_tick_ign", fade_level, 0);

        // full fade in from dark
        req(1, 0);
        chk("fi_busy", fade_busy, 1);
        tick(31);
        chk("fi_t31", fade_level, 15);
        frame_tick = 1; cyc; frame_tick = 0;
        chk("fi_end_done", fade_done, 1);
        chk("fi_end_level", fade_level, 16);
        chk("fi_end_busy", fade_busy, 0);
        cyc;
        chk("fi_done_pulse", fade_done, 0);

        // reversal: out to 10, then back in
        req(0, 1);
        tick(12);
        chk("rev_l10", fade_level, 10);
        look("lvl10", 4'd3, 12'h970);
        req(1, 0);
        chk("rev_busy", fade_busy, 1);
        chk("rev_done", fade_done, 0);
        tick(11);
        chk("rev_t11", fade_level, 15);
        frame_tick = 1; cyc; frame_tick = 0;
        chk("rev_end_done", fade_done, 1);
        chk("rev_end_level", fade_level, 16);
        chk("rev_end_busy", fade_busy, 0);

        // simultaneous requests: fade_out_req wins
        req(1, 1);
        chk("both_busy", fade_busy, 1);
        tick(2);
        chk("both_l15", fade_level, 15);
        req(1, 1);
        tick(2);
        chk("both_l14", fade_level, 14);

        // asynchronous reset mid-fade
        Reset_n = 1'b0;
        #2;
        chk("arst_level", fade_level, 16);
        chk("arst_busy", fade_busy, 0);
        chk("arst_rgb", {red, green, blue}, 12'h000);
        chk("arst_vld", rgb_valid, 0);
        @(negedge Clk); Reset_n = 1'b1;
        cyc;
        look("arst_pal", 4'd3, 12'h000);
        tick(2);
        chk("arst_shown", fade_level, 16);

`ifdef PAL_TRANSPARENT_EN
        wr(4'd7, 12'h456);
        idx_valid = 1; index = 4'd0; cyc;
        index = 4'd7; cyc;
        chk("tr_0", transparent, 1);
        index = 4'd0; cyc;
        chk("tr_7", transparent, 0);
        chk("tr_7_rgb", {red, green, blue}, 12'h456);
        idx_valid = 0; cyc;
        chk("tr_0b", transparent, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
